// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and its dispatch stage: opcodes, request codes
// and the dispatch FSM states.
package alu_pkg;

    // Logic opcodes, passed straight through to the ALU
    localparam logic [3:0] NOTA = 4'd0;
    localparam logic [3:0] NOTB = 4'd1;
    localparam logic [3:0] AND  = 4'd2;
    localparam logic [3:0] OR   = 4'd3;
    localparam logic [3:0] XOR  = 4'd4;
    localparam logic [3:0] NAND = 4'd5;
    localparam logic [3:0] NOR  = 4'd6;
    localparam logic [3:0] XNOR = 4'd7;

    // Sign-coded magnitude adds: {2'b10, sign_a, sign_b}
    localparam logic [3:0] ADDPP = 4'b1000;
    localparam logic [3:0] ADDPN = 4'b1001;
    localparam logic [3:0] ADDNP = 4'b1010;
    localparam logic [3:0] ADDNN = 4'b1011;

    localparam logic [3:0] REQ_ADD = 4'd8;
    localparam logic [3:0] REQ_SUB = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

endpackage

// File: rtl/sm_to_tc.sv
// Sign/magnitude to two's-complement converter for the ALU result path,
// flagging magnitudes that do not fit a signed 32-bit value.
module sm_to_tc (
    input  logic        sign,
    input  logic [31:0] mag,
    output logic [31:0] value,
    output logic        overflow
);

    // A negative zero negates to zero, so no special case is needed
    assign value    = sign ? (~mag + 32'd1) : mag;
    assign overflow = sign ? (mag > 32'h8000_0000) : mag[31];

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage for the sign/magnitude ALU: converts two's-complement requests
// into ALU operands, runs the start/finish handshake and converts the result back.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_error,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic        alu_start,
    input  logic        alu_finish,
    input  logic        alu_sign,
    input  logic [31:0] alu_c
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             alu_used;
    logic             arith;

    logic             req_arith;
    logic             req_legal;
    logic             sign_a;
    logic             sign_b;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [31:0]      tc_value;
    logic             tc_overflow;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        req_arith = (req_op == REQ_ADD) || (req_op == REQ_SUB);
        req_legal = req_arith || (req_op <= XNOR);
        sign_a    = req_a[31];
        sign_b    = (req_op == REQ_SUB) ? ~req_b[31] : req_b[31];
        mag_a     = req_a[31] ? (~req_a + 32'd1) : req_a;
        mag_b     = req_b[31] ? (~req_b + 32'd1) : req_b;
    end

    sm_to_tc result_conv (
        .sign     (alu_sign),
        .mag      (alu_c),
        .value    (tc_value),
        .overflow (tc_overflow)
    );

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            alu_used     <= 1'b0;
            arith        <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            alu_start    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (!req_legal) begin
                            // Illegal opcode answers directly and never touches the ALU
                            alu_used     <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_error    <= 1'b1;
                            rsp_result   <= '0;
                            rsp_overflow <= 1'b0;
                            state        <= RESP;
                        end else begin
                            alu_used <= 1'b1;
                            arith    <= req_arith;
                            if (req_arith) begin
                                alu_a       <= mag_a;
                                alu_b       <= mag_b;
                                alu_control <= {2'b10, sign_a, sign_b};
                            end else begin
                                alu_a       <= req_a;
                                alu_b       <= req_b;
                                alu_control <= req_op;
                            end
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    alu_start <= 1'b1;
                    count     <= '0;
                    state     <= WAIT;
                end

                WAIT: begin
                    count <= count + 1'b1;
                    if (alu_finish) begin
                        alu_start <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        if (arith) begin
                            rsp_result   <= tc_value;
                            rsp_overflow <= tc_overflow;
                        end else begin
                            rsp_result   <= alu_c;
                            rsp_overflow <= 1'b0;
                        end
                        state <= RESP;
                    end else if (count == CNT_W'(TIMEOUT - 1)) begin
                        alu_start    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        state        <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (alu_used) begin
                            state <= DRAIN;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                DRAIN: begin
                    // A finish still high from the last run must not complete the next one
                    if (!alu_finish) begin
                        count     <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    req_ready <= 1'b1;
                    alu_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU and a scoreboard of
// expected responses.
module tb_alu_dispatch;
    import alu_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_error;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic        alu_start;
    logic        alu_finish;
    logic        alu_sign;
    logic [31:0] alu_c;

    // ALU model controls
    logic        m_never;
    int          m_delay;
    logic        m_sign;
    logic [31:0] m_c;
    int          dcnt;

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic        overflow;
        logic        error;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    alu_dispatch #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_error    (rsp_error),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_start    (alu_start),
        .alu_finish   (alu_finish),
        .alu_sign     (alu_sign),
        .alu_c        (alu_c)
    );

    // Behavioural ALU: finishes m_delay cycles after seeing start, holds finish until start drops
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_finish <= 1'b0;
            alu_sign   <= 1'b0;
            alu_c      <= '0;
            dcnt       <= 0;
        end else if (!alu_start) begin
            alu_finish <= 1'b0;
            dcnt       <= 0;
        end else if (!m_never && !alu_finish) begin
            if (dcnt >= m_delay) begin
                alu_finish <= 1'b1;
                alu_sign   <= m_sign;
                alu_c      <= m_c;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        check({tag, " req_ready"}, req_ready, 1);
    endtask

    task automatic do_req(
        input string       tag,
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        drives_alu,
        input logic [3:0]  e_ctl,
        input logic [31:0] e_a,
        input logic [31:0] e_b,
        input logic        s,
        input logic [31:0] c,
        input logic [31:0] e_res,
        input logic        e_ovf,
        input logic        e_err,
        input int          hold,
        input int          min_lat,
        input int          max_lat
    );
        exp_t e;
        logic saw_start;
        int   cyc;
        m_sign = s;
        m_c    = c;
        wait_ready(tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        e.tag      = tag;
        e.result   = e_res;
        e.overflow = e_ovf;
        e.error    = e_err;
        sb.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
        saw_start = 1'b0;
        cyc = 0;
        @(negedge clock);
        while (!rsp_valid && cyc < TIMEOUT + 20) begin
            if (alu_start && !saw_start) begin
                saw_start = 1'b1;
                if (drives_alu) begin
                    check({tag, " alu_control"}, alu_control, e_ctl);
                    check({tag, " alu_a"}, alu_a, e_a);
                    check({tag, " alu_b"}, alu_b, e_b);
                end
            end
            cyc++;
            @(negedge clock);
        end
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " alu_started"}, saw_start, drives_alu);
        check({tag, " latency_in_range"}, (cyc >= min_lat && cyc <= max_lat), 1);
        check({tag, " alu_start_low"}, alu_start, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " rsp_result"}, rsp_result, e.result);
            check({e.tag, " rsp_overflow"}, rsp_overflow, e.overflow);
            check({e.tag, " rsp_error"}, rsp_error, e.error);
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                check({e.tag, " hold rsp_valid"}, rsp_valid, 1);
                check({e.tag, " hold rsp_result"}, rsp_result, e.result);
                check({e.tag, " hold req_ready"}, req_ready, 0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        m_never   = 1'b0;
        m_delay   = 0;
        m_sign    = 1'b0;
        m_c       = '0;

        repeat (2) @(posedge clock);
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset alu_start", alu_start, 0);
        check("reset alu_control", alu_control, 0);
        check("reset rsp_result", rsp_result, 0);
        check("reset rsp_error", rsp_error, 0);
        @(negedge clock);
        reset = 1'b0;

        // Arithmetic paths; latency is accept edge + 3 + ALU delay
        do_req("add_5_m7", REQ_ADD, 32'd5, 32'hFFFF_FFF9, 1, ADDPN, 32'd5, 32'd7,
               1, 32'd2, 32'hFFFF_FFFE, 0, 0, 0, 3, 3);
        m_delay = 2;
        do_req("sub_m3_4", REQ_SUB, 32'hFFFF_FFFD, 32'd4, 1, ADDNN, 32'd3, 32'd4,
               1, 32'd7, 32'hFFFF_FFF9, 0, 0, 0, 5, 5);
        m_delay = 0;
        do_req("add_max_1", REQ_ADD, 32'h7FFF_FFFF, 32'd1, 1, ADDPP, 32'h7FFF_FFFF, 32'd1,
               0, 32'h8000_0000, 32'h8000_0000, 1, 0, 0, 3, 3);
        do_req("add_min_0", REQ_ADD, 32'h8000_0000, 32'd0, 1, ADDNP, 32'h8000_0000, 32'd0,
               1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 3, 3);
        do_req("add_min_m1", REQ_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 1, ADDNN, 32'h8000_0000, 32'd1,
               1, 32'h8000_0001, 32'h7FFF_FFFF, 1, 0, 0, 3, 3);
        do_req("sub_neg_zero", REQ_SUB, 32'd5, 32'd5, 1, ADDPN, 32'd5, 32'd5,
               1, 32'd0, 32'd0, 0, 0, 0, 3, 3);
        do_req("sub_b_zero", REQ_SUB, 32'd9, 32'd0, 1, ADDPN, 32'd9, 32'd0,
               0, 32'd9, 32'd9, 0, 0, 0, 3, 3);

        // Logic op: raw operands, sign ignored, response held under back-pressure
        do_req("and_raw", AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00,
               1, 32'hF000_F000, 32'hF000_F000, 0, 0, 5, 3, 3);

        // Illegal opcode never starts the ALU
        do_req("illegal_12", 4'd12, 32'd1, 32'd2, 0, 4'd0, 32'd0, 32'd0,
               0, 32'd0, 32'd0, 0, 1, 0, 0, 2);

        // ALU never finishes: error after TIMEOUT WAIT cycles (plus accept and ISSUE)
        m_never = 1'b1;
        do_req("timeout", REQ_ADD, 32'd2, 32'd3, 1, ADDPP, 32'd2, 32'd3,
               0, 32'd0, 32'd0, 0, 1, 0, TIMEOUT + 1, TIMEOUT + 1);

        // Reset in the middle of WAIT, checked before any further clock edge
        wait_ready("reset_mid");
        req_valid = 1'b1;
        req_op    = REQ_ADD;
        req_a     = 32'd3;
        req_b     = 32'd4;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!alu_start && n < 10) begin
            n++;
            @(negedge clock);
        end
        check("reset_mid alu_start_before", alu_start, 1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("reset_mid alu_start", alu_start, 0);
        check("reset_mid req_ready", req_ready, 1);
        check("reset_mid rsp_valid", rsp_valid, 0);
        @(negedge clock);
        reset   = 1'b0;
        m_never = 1'b0;

        do_req("add_1_1", REQ_ADD, 32'd1, 32'd1, 1, ADDPP, 32'd1, 32'd1,
               0, 32'd2, 32'd2, 0, 0, 0, 3, 3);

        check("scoreboard empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
